// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with N/Z/V flags and an iterative
// shift-add multiply.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; op, ain, bin captured on accept
//   op                    000 ADD, 001 SUB, 010 AND, 011 MVN, 100 OR,
//                         101 XOR, 110 LSL, 111 MUL
//   out_valid / out_ready result handshake
//   out, z, n, v          registered result and flags
//   busy                  multiply in progress
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             busy
);
    localparam int SH = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] acc, acc_nx, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SH-1:0]      cnt;
    logic [WIDTH-1:0]   res, ld_res;
    logic               res_v, ld_v, load, accept, mul_start;

    // A new request may enter only when idle and the output slot is free
    // (or being drained on this very edge).
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && MUL_EN && (op == 3'b111);
    assign busy      = (state == MUL);

    // Single-cycle result straight from the request operands.
    always_comb begin
        res   = '0;
        res_v = 1'b0;
        case (op)
            3'b000: begin
                res   = ain + bin;
                res_v = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b001: begin
                res   = ain + ~bin + WIDTH'(1);
                res_v = (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b010: res = ain & bin;
            3'b011: res = ~bin;
            3'b100: res = ain | bin;
            3'b101: res = ain ^ bin;
            3'b110: res = ain << bin[SH-1:0];
            default: begin
                // Without the multiplier op 111 is flagged as an overflow.
                res   = '0;
                res_v = 1'b1;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign acc_nx = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        ld_res   = res;
        ld_v     = res_v;
        case (state)
            IDLE: begin
                if (mul_start)   state_nx = MUL;
                else if (accept) load     = 1'b1;
            end
            MUL: begin
                if (cnt == SH'(WIDTH-1)) begin
                    state_nx = IDLE;
                    load     = 1'b1;
                    ld_res   = acc_nx[WIDTH-1:0];
                    ld_v     = |acc_nx[2*WIDTH-1:WIDTH];
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            v         <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            if (load) begin
                out       <= ld_res;
                z         <= (ld_res == '0);
                n         <= ld_res[WIDTH-1];
                v         <= ld_v;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (mul_start) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, ain};
                mplier <= bin;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SH'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed stimulus for alu_seq with a cycle-level reference
// model checked every cycle, plus literal expectations for each scenario.
module tb_alu_seq;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0, in_valid0 = 1'b0, out_ready = 1'b1;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  ain = '0, bin = '0;
    logic          in_ready, out_valid, z, n, v, busy;
    logic [W-1:0]  out;
    logic          in_ready0, out_valid0, z0, n0, v0, busy0;
    logic [W-1:0]  out0;

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .ain(ain), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .z(z), .n(n), .v(v), .busy(busy));

    alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .op(op), .ain(ain), .bin(bin), .out_valid(out_valid0), .out_ready(1'b1),
        .out(out0), .z(z0), .n(n0), .v(v0), .busy(busy0));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference arithmetic using signed range checks and a full-width product.
    function automatic void calc(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output bit vv);
        int sa, sb, s;
        longint unsigned p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        vv = 1'b0;
        case (o)
            3'd0: begin s = sa + sb; r = a + b; vv = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sb; r = a - b; vv = (s > 32767) || (s < -32768); end
            3'd2: r = a & b;
            3'd3: r = ~b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = a << b[3:0];
            default: begin
                p  = longint'(a) * longint'(b);
                r  = p[W-1:0];
                vv = (p >> W) != 0;
            end
        endcase
    endfunction

    int           m_left = 0;
    bit           m_valid = 1'b0, m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;
    logic [W-1:0] m_out = '0, m_a = '0, m_b = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0; m_valid = 0; m_out = '0; m_z = 0; m_n = 0; m_v = 0;
        end else begin
            bit rdy, ld, vv;
            logic [W-1:0] r;
            rdy = (m_left == 0) && (!m_valid || out_ready);
            ld = 0; r = '0; vv = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin calc(3'd7, m_a, m_b, r, vv); ld = 1; end
            end else if (in_valid && rdy) begin
                if (op == 3'd7) begin m_left = W; m_a = ain; m_b = bin; end
                else begin calc(op, ain, bin, r, vv); ld = 1; end
            end
            if (ld) begin
                m_out = r; m_z = (r == 0); m_n = r[W-1]; m_v = vv; m_valid = 1;
            end else if (out_ready) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", in_ready, (m_left == 0) && (!m_valid || out_ready));
            chk("model_out_valid", out_valid, m_valid);
            chk("model_busy", busy, m_left > 0);
            chk("model_result", {out, z, n, v}, {m_out, m_z, m_n, m_v});
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        acc = 0;
        op = o; ain = a; bin = b; in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_res(input string nm, input logic [W-1:0] o, input bit ez, input bit en, input bit ev);
        @(negedge clk);
        chk(nm, {out_valid, out, z, n, v}, {1'b1, o, ez, en, ev});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]   bo [4];
        logic [W-1:0] ba [4], bb [4];
        logic [19:0]  be [4];
        bo[0] = 3'd2; ba[0] = 16'h0011; bb[0] = 16'h0011; be[0] = {1'b1, 16'h0011, 3'b000};
        bo[1] = 3'd3; ba[1] = 16'h1234; bb[1] = 16'hFFFF; be[1] = {1'b1, 16'h0000, 3'b100};
        bo[2] = 3'd5; ba[2] = 16'hAAAA; bb[2] = 16'h5555; be[2] = {1'b1, 16'hFFFF, 3'b010};
        bo[3] = 3'd6; ba[3] = 16'h0001; bb[3] = 16'h0004; be[3] = {1'b1, 16'h0010, 3'b000};

        @(posedge clk); #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {out_valid, busy, in_ready, out, z, n, v}, {3'b001, 16'h0000, 3'b000});
        @(posedge clk); #1;

        send(3'd0, 16'hFFFF, 16'h0001); expect_res("add_wrap", 16'h0000, 1, 0, 0);
        send(3'd0, 16'h7FFF, 16'h0001); expect_res("add_ovf", 16'h8000, 0, 1, 1);
        send(3'd1, 16'h0000, 16'h0001); expect_res("sub_neg", 16'hFFFF, 0, 1, 0);
        send(3'd1, 16'h8000, 16'h0001); expect_res("sub_ovf", 16'h7FFF, 0, 0, 1);
        send(3'd1, 16'hAAAA, 16'hAAAA); expect_res("sub_zero", 16'h0000, 1, 0, 0);

        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = bo[i]; ain = ba[i]; bin = bb[i];
            @(negedge clk);
            chk("b2b_ready", in_ready, 1);
            if (i > 0) chk("b2b_result", {out_valid, out, z, n, v}, be[i-1]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk); chk("b2b_result", {out_valid, out, z, n, v}, be[3]);
        @(posedge clk); #1;

        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'd0, 16'h1234, 16'hDC56);
        op = 3'd4; ain = 16'h0F00; bin = 16'h00F0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, out, z, n, v}, {1'b1, 16'hEE8A, 3'b010});
            chk("bp_ready_low", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); chk("bp_ready_up", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        expect_res("bp_next", 16'h0FF0, 0, 0, 0);

        send(3'd7, 16'h0012, 16'h0034);
        repeat (16) begin
            @(negedge clk); chk("mul_busy", {busy, in_ready, out_valid}, 3'b100);
        end
        @(negedge clk);
        chk("mul_result", {out_valid, busy, out, z, n, v}, {2'b10, 16'h03A8, 3'b000});
        @(posedge clk); #1;

        send(3'd7, 16'h0012, 16'h0034);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 chk("rst_async", {out_valid, busy, out, z, n, v}, 21'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk); chk("rst_ready", in_ready, 1);
        repeat (20) begin
            @(negedge clk); chk("rst_no_late", {out_valid, busy}, 2'b00);
        end
        @(posedge clk); #1;

        send(3'd7, 16'h0100, 16'h0100);
        repeat (16) @(negedge clk);
        @(negedge clk);
        chk("mul_ovf", {out_valid, out, z, n, v}, {1'b1, 16'h0000, 3'b101});
        @(posedge clk); #1;

        op = 3'd7; ain = 16'h0005; bin = 16'h0007; in_valid0 = 1'b1;
        @(negedge clk); chk("nomul_ready", in_ready0, 1);
        @(posedge clk); #1 in_valid0 = 1'b0;
        @(negedge clk);
        chk("nomul_result", {out_valid0, busy0, out0, z0, n0, v0}, {2'b10, 16'h0000, 3'b101});
        @(posedge clk); #1;

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath's 16-bit combinational ALU. Adds a registered result with valid/ready flow control, full N/Z/V status flags, four extra operations and an iterative multi-cycle multiply. It sits between the register-file read stage and write-back, so a stalled consumer or a long multiply back-pressures the issue logic instead of corrupting results.

## Interface
- WIDTH, 16, datapath width in bits (≥4, power of two)
- MUL_EN, 1, 1 = op 111 is an iterative multiply; 0 = op 111 returns 0 with v=1 in one cycle
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 MVN (~bin), 100 OR, 101 XOR, 110 LSL, 111 MUL
- ain, bin  in  WIDTH  operands
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result this cycle
- out  out  WIDTH  registered result
- z, n, v  out  1 each  zero, negative (out[WIDTH-1]), overflow
- busy  out  1  multiply in progress

## Operation
- Request accepted on a rising edge with in_valid && in_ready. op, ain and bin are captured then; later input changes are ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Single-cycle ops therefore sustain one result per cycle.
- States and transitions:
  - IDLE: single-cycle op loads out/flags and sets out_valid. MUL with MUL_EN=1 goes to MUL.
  - MUL: shift-add over WIDTH iterations. Product is 2*WIDTH bits wide internally. The last iteration loads out/flags, sets out_valid and returns to IDLE.
- Arithmetic rules (all mod 2^WIDTH):
  - ADD: v = sign(ain)==sign(bin) && sign(out)!=sign(ain).
  - SUB: out = ain + ~bin + 1; v = sign(ain)!=sign(bin) && sign(out)!=sign(ain).
  - AND, MVN, OR, XOR: v=0.
  - LSL: out = ain << bin[$clog2(WIDTH)-1:0], zero fill, v=0.
  - MUL: unsigned; out = low WIDTH bits of the product; v = (high WIDTH bits != 0).
  - z = (out==0) and n = out[WIDTH-1] for every op.
- Output hold: while out_valid && !out_ready, out/z/n/v stay stable and no new request is accepted.
- out_valid clears on the edge where out_ready=1, unless a new result is loaded on that same edge.

## Timing
- Reset (asynchronous, takes effect immediately):
  - out=0, z=0, n=0, v=0, out_valid=0, busy=0, state=IDLE.
  - in_ready=1 from the first cycle after release.
  - Reset during MUL aborts the multiply; no result is produced.
- Single-cycle ops: accepted at edge k, out_valid=1 after edge k.
- MUL: accepted at edge k; busy=1 and in_ready=0 from edge k to edge k+WIDTH; out_valid=1 after edge k+WIDTH.
- Simultaneous events: out_ready=1 with a new acceptance on the same edge replaces the result without a bubble.
- A MUL cannot start while an undrained result is held, because in_ready is low.
- No combinational path from in_* to out*. in_ready depends combinationally on out_ready only.

## Test plan
- Reset: pulse reset_n low 3 cycles into a MUL of 0x0012*0x0034 -> out=0x0000, flags 0, out_valid=0, busy=0; in_ready=1 after release; no late result appears.
- ADD:
  - 0xFFFF+0x0001 -> 0x0000, z=1 n=0 v=0, one cycle after acceptance.
  - 0x7FFF+0x0001 -> 0x8000, n=1 v=1.
- SUB:
  - 0x0000-0x0001 -> 0xFFFF, n=1 z=0 v=0.
  - 0x8000-0x0001 -> 0x7FFF, v=1.
  - 0xAAAA-0xAAAA -> 0x0000, z=1.
- Back-to-back with out_ready=1: AND 0x0011&0x0011, MVN bin=0xFFFF, XOR 0xAAAA^0x5555, LSL 0x0001 by 4 -> 0x0011, 0x0000 (z=1), 0xFFFF (n=1), 0x0010 on four consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after ADD 0x1234+0xDC56 -> out=0xEE8A held stable, in_ready=0, a pending request is not taken. Raising out_ready drains the result and accepts the next request on the same edge.
- MUL (WIDTH=16):
  - 0x0012*0x0034 -> 0x03A8 exactly 16 cycles after acceptance, v=0, busy=1 and in_ready=0 throughout.
  - 0x0100*0x0100 -> 0x0000, z=1 v=1.
  - With MUL_EN=0, op 111 -> 0x0000, v=1 in one cycle.
